// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between instruction-fetch and data ports
module sram_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                if_stall,
    output logic                mem_stall,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [15:0]         conflict_cnt
);
    localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA_RD} owner_e;

    owner_e      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic [15:0] conflict_q, conflict_d;

    // Per-cycle arbitration: data normally wins, fetch is forced once the streak limit is hit
    always_comb begin
        inst_gnt  = inst_req & (~data_req | (streak_q == MAX_S));
        data_gnt  = data_req & ~inst_gnt;
        if_stall  = inst_req & ~inst_gnt;
        mem_stall = data_req & ~data_gnt;
        mem_en    = inst_gnt | data_gnt;
        mem_addr  = inst_gnt ? inst_addr : data_gnt ? data_addr : '0;
        mem_wen   = data_gnt ? data_wen : '0;
        mem_wdata = data_gnt ? data_wdata : '0;
    end

    // Next owner of the read response, streak and saturating conflict count
    always_comb begin
        owner_d    = inst_gnt ? OWN_INST : (data_gnt && data_wen == '0) ? OWN_DATA_RD : OWN_NONE;
        streak_d   = (inst_gnt | ~inst_req) ? 4'd0 : data_gnt ? streak_q + 4'd1 : streak_q;
        conflict_d = (inst_req & data_req & (conflict_q != 16'hFFFF)) ? conflict_q + 16'd1 : conflict_q;
    end

    // State registers; reset drops any in-flight response immediately
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q    <= OWN_NONE;
            streak_q   <= 4'd0;
            conflict_q <= 16'd0;
        end else begin
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            conflict_q <= conflict_d;
        end
    end

    // Route the SRAM read data to whichever port owns this cycle's response
    always_comb begin
        inst_rvalid  = (owner_q == OWN_INST);
        data_rvalid  = (owner_q == OWN_DATA_RD);
        inst_rdata   = inst_rvalid ? mem_rdata : '0;
        data_rdata   = data_rvalid ? mem_rdata : '0;
        conflict_cnt = conflict_q;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random checks against a behavioural arbiter model
module tb_sram_port_arbiter;
    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0]  data_wen = '0;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid, if_stall, mem_stall, mem_en;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  mem_wen;
    logic [15:0] conflict_cnt;

    int          tests = 0, fails = 0;
    int          m_streak = 0, m_conf = 0, m_pend = 0;
    logic [31:0] m_paddr = '0;
    logic [7:0]  pat = '0;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dval(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    always @(posedge clk) if (mem_en && mem_wen == 4'd0) mem_rdata <= dval(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        logic eig, edg;
        inst_req = ir; inst_addr = ia; data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
        @(negedge clk);
        eig = ir && (!dr || m_streak == MAXS);
        edg = dr && !eig;
        chk("inst_gnt", inst_gnt, eig);
        chk("data_gnt", data_gnt, edg);
        chk("if_stall", if_stall, ir && !eig);
        chk("mem_stall", mem_stall, dr && !edg);
        chk("mem_en", mem_en, eig || edg);
        chk("mem_addr", mem_addr, eig ? ia : edg ? da : 32'd0);
        chk("mem_wen", mem_wen, edg ? dw : 4'd0);
        chk("mem_wdata", mem_wdata, edg ? dd : 32'd0);
        chk("inst_rvalid", inst_rvalid, m_pend == 1);
        chk("inst_rdata", inst_rdata, m_pend == 1 ? dval(m_paddr) : 32'd0);
        chk("data_rvalid", data_rvalid, m_pend == 2);
        chk("data_rdata", data_rdata, m_pend == 2 ? dval(m_paddr) : 32'd0);
        chk("conflict_cnt", conflict_cnt, m_conf);
        pat = {pat[6:0], inst_gnt};
        @(posedge clk);
        #1;
        if (ir && dr && m_conf < 65535) m_conf++;
        m_pend  = eig ? 1 : (edg && dw == 4'd0) ? 2 : 0;
        m_paddr = eig ? ia : da;
        if (!ir || eig) m_streak = 0;
        else if (edg) m_streak++;
    endtask

    task automatic idle();
        step(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rvalid", {inst_rvalid, data_rvalid}, 2'b00);
        chk("reset_conflict", conflict_cnt, 16'd0);
        resetn = 1'b1;
        idle();
        idle();
        // fetch only, consecutive words
        for (int i = 0; i < 4; i++) step(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b0, 4'd0, 32'd0, 32'd0);
        idle();
        // conflict with a read: data first, then fetch
        step(1'b1, 32'hBFC0_0010, 1'b1, 4'd0, 32'h8000_0100, 32'd0);
        step(1'b1, 32'hBFC0_0010, 1'b0, 4'd0, 32'd0, 32'd0);
        idle();
        chk("conflict_one", conflict_cnt, 16'd1);
        // partial store completes at grant with no response
        step(1'b0, 32'd0, 1'b1, 4'b0011, 32'h8000_0200, 32'h1234_5678);
        idle();
        // starvation guard: D D D I D D D I
        for (int i = 0; i < 8; i++) step(1'b1, 32'hBFC0_0100, 1'b1, 4'd0, 32'h8000_1000 + 32'(4 * i), 32'd0);
        chk("streak_pattern", pat, 8'b0001_0001);
        inst_req = 1'b0; data_req = 1'b0;
        idle();
        // reset between data grant and its response
        step(1'b0, 32'd0, 1'b1, 4'd0, 32'h8000_0300, 32'd0);
        inst_req = 1'b0; data_req = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midrst_rvalid", data_rvalid, 1'b0);
        chk("midrst_rdata", data_rdata, 32'd0);
        chk("midrst_conflict", conflict_cnt, 16'd0);
        m_pend = 0; m_streak = 0; m_conf = 0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle();
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? 4'd0 : 4'($urandom), $urandom, $urandom);
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the core's instruction-fetch port and data port.
- Sits between the mips core and the unified memory, replacing separate inst/data SRAMs.
- Arbitrates per cycle, routes read data back to the correct requester, and generates per-port stall signals.
- Includes a starvation guard on fetch and a conflict counter for performance debug.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- MAX_DATA_STREAK, 3, maximum consecutive data wins over a pending fetch before fetch is forced through. Legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request, level.
- inst_addr  in  ADDR_W  fetch address.
- inst_gnt  out  1  fetch accepted this cycle (combinational).
- inst_rvalid  out  1  inst_rdata valid (cycle after grant).
- inst_rdata  out  DATA_W  fetched word.
- data_req  in  1  load/store request, level.
- data_wen  in  DATA_W/8  byte write enables; 0 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  store data.
- data_gnt  out  1  data access accepted this cycle (combinational).
- data_rvalid  out  1  data_rdata valid; asserted only for reads.
- data_rdata  out  DATA_W  load data.
- if_stall  out  1  inst_req & ~inst_gnt.
- mem_stall  out  1  data_req & ~data_gnt.
- mem_en  out  1  SRAM enable.
- mem_wen  out  DATA_W/8  SRAM byte write enables.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after mem_en with mem_wen==0.
- conflict_cnt  out  16  count of cycles where both requests were present; saturates at 0xFFFF.

Behaviour:
- Grant is combinational, at most one grant per cycle:
  - Only one requester active: that requester wins.
  - Both active: data wins, unless streak == MAX_DATA_STREAK, in which case inst wins.
- Memory drive:
  - mem_en = inst_gnt | data_gnt.
  - mem_addr, mem_wen, mem_wdata are muxed from the winner.
  - An inst grant drives mem_wen = 0 and mem_wdata = 0.
  - With no grant, mem_en = 0 and the other memory outputs are 0.
- Response FSM (registered owner): states NONE, INST, DATA_RD.
  - Next state is INST if inst granted.
  - Next state is DATA_RD if data granted with data_wen == 0.
  - Otherwise next state is NONE; data writes return to NONE and complete at grant.
- Response outputs:
  - inst_rvalid = (owner == INST); data_rvalid = (owner == DATA_RD).
  - Both rdata outputs carry mem_rdata when their rvalid is asserted, and are 0 otherwise.
- Latency and throughput:
  - Grant to rvalid is exactly 1 cycle.
  - Back-to-back grants every cycle are allowed, so throughput is 1 access/cycle.
- Streak counter, 4 bits:
  - Increments when data is granted while inst_req = 1.
  - Clears to 0 on inst grant or when inst_req = 0.
  - Never exceeds MAX_DATA_STREAK.
- conflict_cnt increments each cycle inst_req & data_req; it holds at 0xFFFF.
- Requesters hold req and address/data stable until their gnt. If a requester changes its address while stalled, the new value is used; no latching occurs before grant.
- Reset, asynchronous and at any time including mid-access:
  - owner = NONE, streak = 0, conflict_cnt = 0.
  - inst_rvalid, data_rvalid and both rdata outputs go to 0 immediately.
  - An in-flight read response is dropped.
  - Combinational outputs follow the inputs as defined above.
- The block does not check address alignment; alignment is the requester's responsibility.

Test Plan:
- Reset and idle: reset asserted, then no requests -> mem_en = 0, both rvalid = 0, conflict_cnt = 0, both stalls 0.
- Fetch only: inst_req = 1, addr 0xBFC00000 for 4 cycles, memory returns addr-derived data -> inst_gnt = 1 every cycle, inst_rvalid in cycles 1..4 carrying the matching words, if_stall = 0.
- Conflict with read: inst_req and data_req (read, addr 0x80000100) in the same cycle -> data_gnt = 1 and if_stall = 1 that cycle. Next cycle, data_rvalid = 1 with mem_rdata; then fetch is granted. conflict_cnt = 1.
- Store completion: data_req with wen = 4'b0011, wdata 0x12345678 -> mem_wen = 4'b0011 in the grant cycle, no data_rvalid the following cycle.
- Starvation guard (MAX_DATA_STREAK = 3): both requests held continuously -> grant pattern D, D, D, I, D, D, D, I…; streak never exceeds 3.
- Reset mid-read: resetn deasserted in the cycle between data grant and response -> data_rvalid = 0 immediately, owner = NONE, no response after reset release.
